toggle_pulse_gen: RTL and testbench

TOGGLE_PULSE_GEN -- requirements
Module: toggle_pulse_gen

---
 rtl/toggle_pulse_gen_pkg.sv | 15 +
 rtl/toggle_pulse_gen_sync_2ff.sv | 14 +
 rtl/toggle_pulse_gen.sv | 76 +++++++
 tb/tb_toggle_pulse_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/toggle_pulse_gen_pkg.sv
// toggle_pulse_gen_pkg: shared FSM encoding and default debounce depth for the
// button toggle-pulse generator and its bench.
package toggle_pulse_gen_pkg;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        PULSE        = 3'd2,
        HELD         = 3'd3,
        RELEASE_WAIT = 3'd4
    } state_t;
    function automatic logic is_level(input state_t s);
        return s inside {PULSE, HELD, RELEASE_WAIT};
    endfunction
endpackage

// File: rtl/toggle_pulse_gen_sync_2ff.sv
// sync_2ff: two-flop synchronizer bringing the raw button level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1_q, s2_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {s2_q, s1_q} <= 2'b00;
        else     {s2_q, s1_q} <= {s1_q, d};
    end
    assign q = s2_q;
endmodule

// File: rtl/toggle_pulse_gen.sv
// toggle_pulse_gen: debounces a push-button and issues one registered t pulse per
// accepted press, counting pulses modulo 256.
module toggle_pulse_gen
    import toggle_pulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       t_out,
    output logic       btn_level,
    output logic [7:0] pulse_cnt
);
    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d, pulse_cnt_q;
    logic       t_q, level_q, s2;
    sync_2ff u_sync (.clk(clk), .rst(rst), .d(btn_in), .q(s2));
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = s2 ? PRESS_WAIT : IDLE;
                cnt_d   = s2 ? 8'd1 : 8'd0;
            end
            PRESS_WAIT:
                if (!s2) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= LAST) state_d = PULSE;
                else cnt_d = cnt_q + 8'd1;
            PULSE: begin
                state_d = HELD;
                cnt_d   = '0;
            end
            HELD:
                if (!s2) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = 8'd1;
                end
            RELEASE_WAIT:
                if (s2) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 8'd1;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
    // Outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            t_q         <= 1'b0;
            level_q     <= 1'b0;
            pulse_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            t_q         <= state_d == PULSE;
            level_q     <= is_level(state_d);
            pulse_cnt_q <= pulse_cnt_q + 8'(state_d == PULSE);
        end
    end
    assign t_out     = t_q;
    assign btn_level = level_q;
    assign pulse_cnt = pulse_cnt_q;
endmodule

// File: tb/tb_toggle_pulse_gen.sv
// tb_toggle_pulse_gen: directed presses with hand-computed pulse/level edges,
// checked against the DUT by an independent negedge monitor.
module tb_toggle_pulse_gen;
    import toggle_pulse_gen_pkg::*;
    typedef struct {
        int         e;
        logic [7:0] v;
    } ev_t;
    logic       clk, rst, btn_in, t_out, btn_level;
    logic [7:0] pulse_cnt, exp_cnt;
    int         cyc, checks, errors;
    ev_t        pq[$], lq[$];
    ev_t        ev;
    logic       prev_t, prev_l;

    toggle_pulse_gen #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .t_out(t_out), .btn_level(btn_level), .pulse_cnt(pulse_cnt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press for hold>=5 cycles from now: pulse and level rise 6 edges later,
    // level falls 6 edges after the release is driven.
    task automatic clean_press(input int hold);
        int c;
        c = cyc;
        exp_cnt = exp_cnt + 8'd1;
        pq.push_back('{c + 6, exp_cnt});
        lq.push_back('{c + 6, 1'b1});
        lq.push_back('{c + hold + 6, 1'b0});
        btn_in = 1;
        tick(hold);
        btn_in = 0;
        tick(8);
    endtask

    initial begin
        prev_t = 0;
        prev_l = 0;
        forever begin
            @(negedge clk);
            if (t_out === 1'b1) begin
                chk("t_out_not_consecutive", prev_t, 0);
                chk("pulse_queued", 32'(pq.size() > 0), 1);
                if (pq.size() > 0) begin
                    ev = pq.pop_front();
                    chk("pulse_edge", cyc, ev.e);
                    chk("pulse_cnt_at_pulse", pulse_cnt, ev.v);
                end
            end
            if (btn_level !== prev_l) begin
                chk("level_change_queued", 32'(lq.size() > 0), 1);
                if (lq.size() > 0) begin
                    ev = lq.pop_front();
                    chk("level_edge", cyc, ev.e);
                    chk("level_value", btn_level, ev.v);
                end
            end
            prev_t = t_out;
            prev_l = btn_level;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c, k, r;
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;
        rst     = 1;
        btn_in  = 0;
        tick(3);
        chk("reset_t_out", t_out, 0);
        chk("reset_level", btn_level, 0);
        chk("reset_pulse_cnt", pulse_cnt, 0);
        chk("reset_state", dut.state_q, IDLE);
        rst = 0;
        tick(2);

        clean_press(20);

        btn_in = 1; tick(2); btn_in = 0; tick(10);
        btn_in = 1; tick(3); btn_in = 0; tick(10);
        chk("glitch_pulse_cnt", pulse_cnt, 1);
        chk("glitch_level", btn_level, 0);

        c = cyc;
        pq.push_back('{c + 6, 8'd2});
        lq.push_back('{c + 6, 1'b1});
        lq.push_back('{c + 11, 1'b0});
        btn_in = 1; tick(4); btn_in = 0; tick(12);
        exp_cnt = 2;

        c = cyc;
        pq.push_back('{c + 6, 8'd3});
        lq.push_back('{c + 6, 1'b1});
        btn_in = 1;
        tick(10);
        r = cyc;
        for (int i = 0; i < 6; i++) begin
            btn_in = i[0];
            tick(1);
        end
        btn_in = 0;
        lq.push_back('{r + 12, 1'b0});
        tick(12);
        chk("bounce_pulse_cnt", pulse_cnt, 3);
        exp_cnt = 3;

        c = cyc;
        pq.push_back('{c + 6, 8'd4});
        lq.push_back('{c + 6, 1'b1});
        btn_in = 1;
        tick(10);
        k = cyc;
        #1;
        lq.push_back('{k, 1'b0});
        btn_in = 0;
        rst = 1;
        #1;
        chk("async_rst_t_out", t_out, 0);
        chk("async_rst_level", btn_level, 0);
        chk("async_rst_pulse_cnt", pulse_cnt, 0);
        chk("async_rst_state", dut.state_q, IDLE);
        #1;
        rst = 0;
        exp_cnt = 0;
        tick(10);

        c = cyc;
        pq.push_back('{c + 6, 8'd1});
        lq.push_back('{c + 6, 1'b1});
        btn_in = 1;
        tick(10);
        k = cyc;
        lq.push_back('{k, 1'b0});
        rst = 1;
        tick(2);
        rst = 0;
        pq.push_back('{k + 8, 8'd1});
        lq.push_back('{k + 8, 1'b1});
        tick(15);
        lq.push_back('{cyc + 6, 1'b0});
        btn_in = 0;
        tick(10);
        chk("rst_held_pulse_cnt", pulse_cnt, 1);

        rst = 1;
        tick(1);
        rst = 0;
        exp_cnt = 0;
        tick(2);
        for (int i = 0; i < 256; i++) clean_press(5);
        chk("wrap_pulse_cnt", pulse_cnt, 0);

        tick(5);
        chk("pulse_queue_drained", pq.size(), 0);
        chk("level_queue_drained", lq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
